imem_arbiter: RTL

Sequencing and arbitration controller for the word-addressed instruction memory. It holds the pipeline in a boot state while a program loader fills the memory, then shares the single memory port between the IF stage (priority) and loader/debug accesses (cycle stealing). It sits between the IF stage, the loader/debug port and the memory's address, read-data and write port, and enforces a minimum fetch bandwidth so the pipeline cannot be starved.

---
 rtl/imem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: boot-time loader ownership, then IF-priority
// sharing with single-cycle loader steals separated by a minimum fetch window.
module imem_arbiter #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned MIN_FETCH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            if_addr,
  output logic [31:0]            if_rdata,
  output logic                   if_stall,
  output logic                   cpu_hold,
  input  logic                   ld_valid,
  input  logic                   ld_we,
  input  logic [31:0]            ld_addr,
  input  logic [31:0]            ld_wdata,
  input  logic                   ld_done,
  output logic                   ld_ready,
  output logic [31:0]            ld_rdata,
  output logic                   ld_rvalid,
  output logic                   ld_err,
  output logic [31:0]            mem_addr,
  output logic                   mem_we,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic [$clog2(DEPTH):0] wr_count
);

  localparam logic [31:0]     NOP        = 32'h0000_0013;
  localparam int unsigned     GW         = $clog2(MIN_FETCH + 2);
  localparam logic [GW-1:0]   GUARD_LOAD = GW'(MIN_FETCH);
  localparam int unsigned     CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   WR_MAX     = CW'(DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STEAL
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] guard;
  logic [GW-1:0] guard_dec;
  logic          ld_own;
  logic          ld_acc;
  logic          ld_ok;

  // Address check: word aligned and inside the memory.
  always_comb begin
    ld_ok = (ld_addr[1:0] == 2'b00) && (ld_addr[31:2] < 30'(DEPTH));
  end

  // Guard value after this cycle's fetch; a steal is allowed once it reaches
  // zero, so exactly MIN_FETCH RUN cycles separate two STEAL cycles.
  always_comb begin
    guard_dec = (guard == '0) ? '0 : guard - 1'b1;
  end

  // State register and fetch guard counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      guard <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        STEAL:   guard <= GUARD_LOAD;
        RUN:     guard <= guard_dec;
        default: guard <= guard;
      endcase
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    if (ld_done) state_nxt = RUN;
      RUN:     if (ld_valid && (guard_dec == '0)) state_nxt = STEAL;
      STEAL:   state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Port ownership, handshake and memory drive.
  always_comb begin
    ld_own    = (state != RUN);
    cpu_hold  = (state == BOOT);
    if_stall  = ld_own;
    case (state)
      BOOT:    ld_ready = ld_valid;
      STEAL:   ld_ready = 1'b1;
      default: ld_ready = 1'b0;
    endcase
    ld_acc    = ld_ready & ld_valid;
    mem_addr  = ld_own ? ld_addr : if_addr;
    mem_we    = ld_acc & ld_ok & ld_we;
    mem_wdata = ld_own ? ld_wdata : '0;
    if_rdata  = ld_own ? NOP : mem_rdata;
  end

  // Registered loader response and saturating write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rvalid <= 1'b0;
      ld_err    <= 1'b0;
      ld_rdata  <= '0;
      wr_count  <= '0;
    end else begin
      ld_rvalid <= ld_acc & ld_ok & ~ld_we;
      ld_err    <= ld_acc & ~ld_ok;
      if (ld_acc && ld_ok && !ld_we) begin
        ld_rdata <= mem_rdata;
      end
      if (ld_acc && ld_ok && ld_we && (wr_count != WR_MAX)) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

endmodule
